// File: rtl/decode_stage_p.sv
// decode_stage_p: register file, instruction decode and ID/EX register
// with write-through bypass, load-use interlock and stall/flush handling.
module decode_stage_p #(
    parameter int DATA_W = 16,
    parameter int REG_CNT = 8,
    parameter int INSTR_W = 32,
    parameter int CTRL_W = 11,
    localparam int ADDR_W = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic               stall_in,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [ADDR_W-1:0]  ex_rs1,
    output logic [ADDR_W-1:0]  ex_rs2,
    output logic [ADDR_W-1:0]  ex_rd
);
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [2:0]        opc;
    logic [ADDR_W-1:0] rs1, rs2, rd;
    logic              sub, useRs1, useRs2, unusedBits;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd1, rd2, imm;

    assign opc = instr[15:13];
    assign rs1 = instr[12 -: ADDR_W];
    assign rs2 = instr[12-ADDR_W -: ADDR_W];
    assign rd = instr[12-2*ADDR_W -: ADDR_W];
    assign sub = instr[0];
    assign unusedBits = ^instr;
    assign imm = DATA_W'($signed(instr[31:16]));

    always_comb begin
        ctrl = '0;
        case (opc)
            3'b001: ctrl = 11'h041;
            3'b010: ctrl = 11'h043;
            3'b011: ctrl = 11'h05A;
            3'b100: ctrl = 11'h006;
            3'b101: ctrl = 11'h020;
            3'b110: ctrl = sub ? 11'h100 : 11'h0C0;
            3'b111: ctrl = sub ? 11'h258 : 11'h604;
            default: ctrl = '0;
        endcase
    end

    // NOP, IN and POP are the only encodings that ignore rs1
    assign useRs1 = (opc != 3'b000) && !(opc == 3'b110 && !sub) && !(opc == 3'b111 && sub);
    assign useRs2 = (opc == 3'b001) || (opc == 3'b100);

    assign rd1 = (wb_we && wb_addr == rs1) ? wb_data : regs[rs1];
    assign rd2 = (wb_we && wb_addr == rs2) ? wb_data : regs[rs2];

    assign hazard_stall = in_valid && ex_valid && ex_ctrl[3] && ex_ctrl[6] &&
                          ((useRs1 && rs1 == ex_rd) || (useRs2 && rs2 == ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // a hazard bubble is suppressed by stall_in so the held entry survives
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall_in && hazard_stall)) begin
            ex_valid <= 1'b0;
            ex_ctrl <= '0;
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_imm <= '0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
            ex_rd <= '0;
        end else if (!stall_in) begin
            ex_valid <= in_valid;
            ex_ctrl <= in_valid ? ctrl : '0;
            ex_rd1 <= rd1;
            ex_rd2 <= rd2;
            ex_imm <= imm;
            ex_rs1 <= rs1;
            ex_rs2 <= rs2;
            ex_rd <= rd;
        end
    end
endmodule
